// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: core store port, load-forwarding port, memory drain port
// and occupancy status.
//   master : the core/memory side (drives the requests and mem_ready).
//   slave  : the store buffer (drives stall, forwarding, drain and status).
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Core store port
    logic          MemWriteM;
    logic [AW-1:0] DataAdrM;
    logic [DW-1:0] WriteDataM;
    logic          StallSB;

    // Load forwarding port
    logic [AW-1:0] LdAdr;
    logic          FwdHit;
    logic [DW-1:0] FwdData;

    // Memory drain port
    logic          mem_valid;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;

    // Status
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport master (
        output MemWriteM, DataAdrM, WriteDataM, LdAdr, mem_ready,
        input  StallSB, FwdHit, FwdData, mem_valid, mem_adr, mem_wdata,
               count, empty, full
    );

    modport slave (
        input  MemWriteM, DataAdrM, WriteDataM, LdAdr, mem_ready,
        output StallSB, FwdHit, FwdData, mem_valid, mem_adr, mem_wdata,
               count, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core's Memory stage and data memory.
// Captures stores into a circular FIFO, drains them in order over valid/ready,
// forwards the youngest same-word store to loads, and stalls the core when full.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   sb    : store_buffer_if.slave (core store port, forwarding port, memory
//           drain port, count/empty/full status)
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave sb
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic          w_fwd_hit;
    logic [DW-1:0] w_fwd_data;

    // Occupancy flags and handshake decisions; enqueue uses pre-edge full only
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
        w_enq   = sb.MemWriteM & ~w_full;
        w_deq   = ~w_empty & sb.mem_ready;
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; validity is tracked solely by the pointers and count
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= '{adr: sb.DataAdrM, data: sb.WriteDataM};
        end
    end

    // Forwarding: walk entries oldest to youngest so the last match wins.
    // The head stays visible even while it is being dequeued.
    always_comb begin
        logic [PW-1:0] w_idx;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PW'(k);
            if ((CW'(k) < r_count) &&
                (r_mem[w_idx].adr[AW-1:2] == sb.LdAdr[AW-1:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_mem[w_idx].data;
            end
        end
    end

    // Output mapping
    always_comb begin
        sb.StallSB   = sb.MemWriteM & w_full;
        sb.FwdHit    = w_fwd_hit;
        sb.FwdData   = w_fwd_data;
        sb.mem_valid = ~w_empty;
        sb.mem_adr   = r_mem[r_rd_ptr].adr;
        sb.mem_wdata = r_mem[r_rd_ptr].data;
        sb.count     = r_count;
        sb.empty     = w_empty;
        sb.full      = w_full;
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based model of the buffer is
// compared against the DUT every cycle, with directed scenarios and a
// randomized run.
module tb_store_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } st_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .sb    (bus.slave)
    );

    st_t model_q[$];
    st_t mem_log[$];
    int  checks   = 0;
    int  failures = 0;

    logic          s_stall;
    logic          s_hit;
    logic          s_valid;
    logic [DW-1:0] s_fwd;
    logic [63:0]   s_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare against the
    // model, advance the model for the coming rising edge.
    task automatic step(input logic rst, input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] data, input logic [AW-1:0] ld, input logic rdy);
        int            n;
        logic          exp_hit;
        logic [DW-1:0] exp_fwd;
        @(negedge clk);
        rst_n          = rst;
        bus.MemWriteM  = we;
        bus.DataAdrM   = adr;
        bus.WriteDataM = data;
        bus.LdAdr      = ld;
        bus.mem_ready  = rdy;
        #1;
        if (!rst) model_q.delete();
        n       = model_q.size();
        exp_hit = 1'b0;
        exp_fwd = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (model_q[i].adr[AW-1:2] == ld[AW-1:2]) begin
                exp_hit = 1'b1;
                exp_fwd = model_q[i].data;
                break;
            end
        end
        chk("count",     64'(bus.count),     64'(n));
        chk("empty",     64'(bus.empty),     64'(n == 0));
        chk("full",      64'(bus.full),      64'(n == int'(DEPTH)));
        chk("mem_valid", 64'(bus.mem_valid), 64'(n > 0));
        chk("StallSB",   64'(bus.StallSB),   64'(we && n == int'(DEPTH)));
        chk("FwdHit",    64'(bus.FwdHit),    64'(exp_hit));
        chk("FwdData",   64'(bus.FwdData),   64'(exp_fwd));
        if (n > 0) begin
            chk("mem_adr",   64'(bus.mem_adr),   64'(model_q[0].adr));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(model_q[0].data));
        end
        s_stall = bus.StallSB;
        s_hit   = bus.FwdHit;
        s_fwd   = bus.FwdData;
        s_valid = bus.mem_valid;
        s_count = 64'(bus.count);
        if (rst) begin
            if (bus.mem_valid && rdy) mem_log.push_back(st_t'{adr: bus.mem_adr, data: bus.mem_wdata});
            if (n > 0 && rdy) void'(model_q.pop_front());
            if (we && n < int'(DEPTH)) model_q.push_back(st_t'{adr: adr, data: data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 1'b0, '0, '0, '0, rdy);
    endtask

    task automatic chk_log(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (i < mem_log.size()) begin
            chk("log_adr",  64'(mem_log[i].adr),  64'(a));
            chk("log_data", 64'(mem_log[i].data), 64'(d));
        end else begin
            chk("log_len", 64'(mem_log.size()), 64'(i + 1));
        end
    endtask

    initial begin
        bus.MemWriteM  = 1'b0;
        bus.DataAdrM   = '0;
        bus.WriteDataM = '0;
        bus.LdAdr      = '0;
        bus.mem_ready  = 1'b0;

        // Reset then idle
        step(1'b0, 1'b1, 32'h10, 32'h1, 32'h10, 1'b1);
        step(1'b0, 1'b1, 32'h10, 32'h1, 32'h10, 1'b1);
        chk("rst_stall", 64'(s_stall), 64'd0);
        chk("rst_valid", 64'(s_valid), 64'd0);
        chk("rst_count", s_count,      64'd0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("idle_empty", 64'(bus.empty), 64'd1);

        // In-order drain
        mem_log.delete();
        step(1'b1, 1'b1, 32'h10, 32'hA, '0, 1'b0);
        step(1'b1, 1'b1, 32'h14, 32'hB, '0, 1'b0);
        step(1'b1, 1'b1, 32'h18, 32'hC, '0, 1'b0);
        chk("drain_count3", 64'(bus.count), 64'd3);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk_log(0, 32'h10, 32'hA);
        chk_log(1, 32'h14, 32'hB);
        chk_log(2, 32'h18, 32'hC);
        chk("drain_len",   64'(mem_log.size()), 64'd3);
        chk("drain_empty", 64'(bus.empty),      64'd1);

        // Full stall
        mem_log.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(32'h20 + 4 * i), 32'(32'h200 + i), '0, 1'b0);
        chk("full_flag", 64'(bus.full), 64'd1);
        step(1'b1, 1'b1, 32'h30, 32'h204, '0, 1'b0);
        chk("stall_5th", 64'(s_stall), 64'd1);
        step(1'b1, 1'b1, 32'h30, 32'h204, '0, 1'b0);
        chk("stall_held", 64'(s_stall), 64'd1);
        step(1'b1, 1'b1, 32'h30, 32'h204, '0, 1'b1);
        chk("stall_during_drain", 64'(s_stall),   64'd1);
        chk("count_after_pulse",  64'(bus.count), 64'd3);
        step(1'b1, 1'b1, 32'h30, 32'h204, '0, 1'b0);
        chk("stall_released",    64'(s_stall),   64'd0);
        chk("count_after_accept", 64'(bus.count), 64'd4);
        for (int i = 0; i < 5; i++) idle(1'b1);
        for (int i = 0; i < 5; i++) chk_log(i, 32'(32'h20 + 4 * i), 32'(32'h200 + i));

        // Forwarding: youngest match wins, byte offset ignored
        mem_log.delete();
        step(1'b1, 1'b1, 32'h40, 32'h1, '0, 1'b0);
        step(1'b1, 1'b1, 32'h44, 32'h2, '0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 32'h3, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 32'h40, 1'b0);
        chk("fwd40_hit",  64'(s_hit), 64'd1);
        chk("fwd40_data", 64'(s_fwd), 64'd3);
        step(1'b1, 1'b0, '0, '0, 32'h43, 1'b0);
        chk("fwd43_data", 64'(s_fwd), 64'd3);
        step(1'b1, 1'b0, '0, '0, 32'h48, 1'b0);
        chk("fwd48_hit",  64'(s_hit), 64'd0);
        chk("fwd48_data", 64'(s_fwd), 64'd0);
        step(1'b1, 1'b0, '0, '0, 32'h44, 1'b1);
        chk("fwd44_data", 64'(s_fwd), 64'd2);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Back-to-back enqueue/dequeue across pointer wrap
        mem_log.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 32'(32'h100 + 4 * i), 32'(32'h50 + i), '0, 1'b1);
            chk("wrap_stall", 64'(s_stall),   64'd0);
            chk("wrap_count", 64'(bus.count), 64'd1);
        end
        idle(1'b1);
        for (int i = 0; i < 10; i++) chk_log(i, 32'(32'h100 + 4 * i), 32'(32'h50 + i));

        // Reset mid-operation
        mem_log.delete();
        step(1'b1, 1'b1, 32'h60, 32'h7, '0, 1'b0);
        step(1'b1, 1'b1, 32'h64, 32'h8, '0, 1'b0);
        step(1'b1, 1'b1, 32'h68, 32'h9, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 32'h60, 1'b0);
        chk("midrst_valid", 64'(s_valid), 64'd0);
        chk("midrst_count", s_count,      64'd0);
        chk("midrst_hit",   64'(s_hit),   64'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("midrst_nolog", 64'(mem_log.size()), 64'd0);

        // Randomized traffic with varying memory back-pressure
        for (int blk = 0; blk < 15; blk++) begin
            int unsigned bias;
            bias = $urandom_range(0, 4);
            for (int c = 0; c < 200; c++) begin
                step(($urandom_range(0, 149) != 0),
                     1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 15)) << 2,
                     32'($urandom),
                     (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) < bias));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
